disp_scan_mux: RTL and testbench

//   Time-multiplexed scanner for an N-digit common-anode/cathode 7-segment display.

---
 rtl/disp_pkg.sv | 12 +
 rtl/disp_tick_gen.sv | 34 +++
 rtl/disp_scan_mux.sv | 167 ++++++++++++++++
 tb/tb_disp_scan_mux.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared types and constants for the multiplexed 7-segment scanner.
package disp_pkg;

  localparam int unsigned DIG_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_t;

endpackage

// File: rtl/disp_tick_gen.sv
// Slot counter for the scanner: counts 0..DIV_CNT-1 while running and
// flags the end of the blank phase, the end of the slot and the cycle before it.
module disp_tick_gen #(
  parameter int unsigned DIV_CNT   = 50000,
  parameter int unsigned BLANK_CYC = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic blank_end_c,
  output logic slot_end_c,
  output logic slot_pre_end_c
);

  localparam int unsigned CNT_W = $clog2(DIV_CNT);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!run || slot_end_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign blank_end_c    = (cnt == CNT_W'(BLANK_CYC - 1));
  assign slot_end_c     = (cnt == CNT_W'(DIV_CNT - 1));
  // The next cycle will be the last one of the slot.
  assign slot_pre_end_c = run && (cnt == CNT_W'(DIV_CNT - 2));

endmodule

// File: rtl/disp_scan_mux.sv
// N-digit 7-segment scanner with dead-time blanking and frame-synchronous update.
// Optional leading-zero suppression when LZ_BLANK_EN is defined.
module disp_scan_mux
  import disp_pkg::*;
#(
  parameter int unsigned N_DIGITS   = 4,
  parameter int unsigned DIV_CNT    = 50000,
  parameter int unsigned BLANK_CYC  = 64,
  parameter bit          SEL_ACT_LO = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      load,
  input  logic [DIG_W*N_DIGITS-1:0] digits_in,
  output logic [DIG_W-1:0]          data_out,
  output logic [N_DIGITS-1:0]       dig_sel,
  output logic                      frame_done
);

  localparam int unsigned IDX_W  = $clog2(N_DIGITS);
  localparam int unsigned WORD_W = DIG_W * N_DIGITS;
  localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] SEL_OFF  = {N_DIGITS{SEL_ACT_LO}};

  scan_state_t       state, state_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [WORD_W-1:0] shadow, active, active_nxt;
  logic              pending, pending_nxt;
  logic              run, frame_bnd;
  logic              blank_end_c, slot_end_c, slot_pre_end_c;
  logic [DIG_W-1:0]  data_nxt, digit_nxt;
  logic [N_DIGITS-1:0] sel_nxt, show_mask;
  logic              fd_nxt;

  assign run = en && (state != IDLE);

  disp_tick_gen #(
    .DIV_CNT   (DIV_CNT),
    .BLANK_CYC (BLANK_CYC)
  ) u_tick (
    .clk            (clk),
    .rst_n          (rst_n),
    .run            (run),
    .blank_end_c    (blank_end_c),
    .slot_end_c     (slot_end_c),
    .slot_pre_end_c (slot_pre_end_c)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    if (!en) begin
      state_nxt = IDLE;
      idx_nxt   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          state_nxt = BLANK;
          idx_nxt   = '0;
        end
        BLANK: if (blank_end_c) state_nxt = SHOW;
        SHOW: if (slot_end_c) begin
          state_nxt = BLANK;
          idx_nxt   = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
        end
        default: begin
          state_nxt = IDLE;
          idx_nxt   = '0;
        end
      endcase
    end
  end

  // Frame boundary: end of the last digit's slot, or scan start from IDLE.
  assign frame_bnd = en && (((state == SHOW) && slot_end_c && (idx == IDX_LAST)) ||
                            (state == IDLE));

  // Shadow/active double buffer; a load at the boundary itself wins.
  always_comb begin
    active_nxt  = active;
    pending_nxt = pending;
    if (frame_bnd) begin
      if (load) begin
        active_nxt = digits_in;
      end else if (pending) begin
        active_nxt = shadow;
      end
      pending_nxt = 1'b0;
    end else if (load) begin
      pending_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow  <= '0;
      active  <= '0;
      pending <= 1'b0;
    end else begin
      if (load) shadow <= digits_in;
      active  <= active_nxt;
      pending <= pending_nxt;
    end
  end

  always_comb begin
    digit_nxt = '0;
    for (int i = 0; i < int'(N_DIGITS); i++) begin
      if (idx_nxt == IDX_W'(i)) digit_nxt = active_nxt[i*DIG_W +: DIG_W];
    end
  end

`ifdef LZ_BLANK_EN
  // A digit is suppressed while it and everything above it are zero.
  always_comb begin
    logic lead;
    lead      = 1'b1;
    show_mask = '1;
    for (int i = int'(N_DIGITS) - 1; i >= 1; i--) begin
      lead         = lead && (active_nxt[i*DIG_W +: DIG_W] == '0);
      show_mask[i] = !lead;
    end
  end
`else
  assign show_mask = '1;
`endif

  // Output logic, evaluated on the upcoming state so the registers line up with it
  always_comb begin
    data_nxt = '0;
    sel_nxt  = '0;
    fd_nxt   = 1'b0;
    if (state_nxt != IDLE) data_nxt = digit_nxt;
    if (state_nxt == SHOW) begin
      for (int i = 0; i < int'(N_DIGITS); i++) begin
        if ((idx_nxt == IDX_W'(i)) && show_mask[i]) sel_nxt[i] = 1'b1;
      end
      fd_nxt = (idx_nxt == IDX_LAST) && slot_pre_end_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out   <= '0;
      dig_sel    <= SEL_OFF;
      frame_done <= 1'b0;
    end else begin
      data_out   <= data_nxt;
      dig_sel    <= sel_nxt ^ SEL_OFF;
      frame_done <= fd_nxt;
    end
  end

endmodule

// File: tb/tb_disp_scan_mux.sv
// Directed self-checking bench for disp_scan_mux (N=4, DIV_CNT=8, BLANK_CYC=2, active-low select).
module tb_disp_scan_mux;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [15:0] digits_in = 16'h0;
  logic [3:0]  data_out;
  logic [3:0]  dig_sel;
  logic        frame_done;

  int total = 0;
  int bad   = 0;

  disp_scan_mux #(
    .N_DIGITS   (4),
    .DIV_CNT    (8),
    .BLANK_CYC  (2),
    .SEL_ACT_LO (1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .load       (load),
    .digits_in  (digits_in),
    .data_out   (data_out),
    .dig_sel    (dig_sel),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected outputs at cycle t of a running scan showing word w.
  task automatic check_slot(input string tag, input int t, input logic [15:0] w);
    int         pos, di;
    logic [3:0] exp_d, exp_s;
    logic       exp_f, lead, show_ok;
    pos   = t % 8;
    di    = (t / 8) % 4;
    exp_d = w[di*4 +: 4];
    lead  = 1'b1;
    for (int j = 3; j >= di; j--) begin
      if (w[j*4 +: 4] != 4'h0) lead = 1'b0;
    end
`ifdef LZ_BLANK_EN
    show_ok = (di == 0) || !lead;
`else
    show_ok = 1'b1;
`endif
    exp_s = 4'b1111;
    if (pos >= 2 && show_ok) exp_s[di] = 1'b0;
    exp_f = (pos == 7) && (di == 3);
    chk($sformatf("%s_t%0d_data", tag, t), 8'(data_out), 8'(exp_d));
    chk($sformatf("%s_t%0d_sel", tag, t), 8'(dig_sel), 8'(exp_s));
    chk($sformatf("%s_t%0d_fd", tag, t), 8'(frame_done), 8'(exp_f));
  endtask

  initial begin
    logic [15:0] w;

    // Reset values
    @(negedge clk);
    chk("rst_data", 8'(data_out), 8'h0);
    chk("rst_sel", 8'(dig_sel), 8'hF);
    chk("rst_fd", 8'(frame_done), 8'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_sel", 8'(dig_sel), 8'hF);
    chk("idle_fd", 8'(frame_done), 8'h0);

    // Start with a load coincident with IDLE->BLANK; mid-frame and boundary loads follow
    en = 1'b1; load = 1'b1; digits_in = 16'h4321;
    @(negedge clk);
    for (int t = 0; t <= 148; t++) begin
      w = (t < 64) ? 16'h4321 : (t < 96) ? 16'h9876 : 16'hA5C3;
      check_slot("scan", t, w);
      load = 1'b0;
      if (t == 40) begin load = 1'b1; digits_in = 16'h9876; end
      if (t == 95) begin load = 1'b1; digits_in = 16'hA5C3; end
      if (t != 148) @(negedge clk);
    end

    // Disable during SHOW of digit 2
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("dis_sel_%0d", k), 8'(dig_sel), 8'hF);
      chk($sformatf("dis_fd_%0d", k), 8'(frame_done), 8'h0);
    end
    en = 1'b1;
    @(negedge clk);
    for (int t = 0; t <= 17; t++) begin
      check_slot("restart", t, 16'hA5C3);
      load = 1'b0;
      if (t == 10) begin load = 1'b1; digits_in = 16'h1111; end
      if (t != 17) @(negedge clk);
    end

    // Asynchronous reset in the blank phase with a pending load outstanding
    #2;
    rst_n = 1'b0;
    load  = 1'b0;
    #1;
    chk("arst_data", 8'(data_out), 8'h0);
    chk("arst_sel", 8'(dig_sel), 8'hF);
    chk("arst_fd", 8'(frame_done), 8'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int t = 0; t < 8; t++) begin
      check_slot("post_rst", t, 16'h0000);
      @(negedge clk);
    end

    // Zero digits and out-of-range nibbles from an IDLE restart
    en = 1'b0;
    @(negedge clk);
    en = 1'b1; load = 1'b1; digits_in = 16'h0050;
    @(negedge clk);
    load = 1'b0;
    for (int t = 0; t < 32; t++) begin
      check_slot("lz", t, 16'h0050);
      @(negedge clk);
    end
    en = 1'b0;
    @(negedge clk);
    en = 1'b1; load = 1'b1; digits_in = 16'hFB0E;
    @(negedge clk);
    load = 1'b0;
    for (int t = 0; t < 32; t++) begin
      check_slot("hex", t, 16'hFB0E);
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
